// File: rtl/freq_analyzer_if.sv
// freq_analyzer_if: FFT bin frame into the analyzer, peak report back out
interface freq_analyzer_if #(parameter int DW = 16);
  logic fft_valid;
  logic [2*DW-1:0] fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7;
  logic [2*DW-1:0] fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15;
  logic done;
  logic [3:0] freq;
  logic [2*DW-1:0] peak_mag;
  logic busy;
  modport master (
    output fft_valid, fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
           fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15,
    input  done, freq, peak_mag, busy
  );
  modport slave (
    input  fft_valid, fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
           fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15,
    output done, freq, peak_mag, busy
  );
endinterface

// File: rtl/freq_analyzer.sv
// freq_analyzer: sequential 16-bin squared-magnitude scan reporting the strongest bin
module freq_analyzer #(parameter int DW = 16) (
  input logic clk,
  input logic rst,
  freq_analyzer_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] REPORT = 2'd2;
  logic [1:0] state;
  logic [3:0] idx, best, freq_q;
  logic [2*DW-1:0] max, peak_q, mag, nmax, word;
  logic [2*DW-1:0] din [16];
  logic [2*DW-1:0] frame [16];
  logic signed [2*DW-1:0] re, im;
  logic cap, upd;
  assign din = '{bus.fft_d0, bus.fft_d1, bus.fft_d2, bus.fft_d3, bus.fft_d4, bus.fft_d5,
                 bus.fft_d6, bus.fft_d7, bus.fft_d8, bus.fft_d9, bus.fft_d10, bus.fft_d11,
                 bus.fft_d12, bus.fft_d13, bus.fft_d14, bus.fft_d15};
  assign cap = bus.fft_valid && (state == IDLE || state == REPORT);
  assign word = frame[idx];
  assign re = {{DW{word[2*DW-1]}}, word[2*DW-1:DW]};
  assign im = {{DW{word[DW-1]}}, word[DW-1:0]};
  // Worst case sums to exactly 2^(2*DW-1), so the unsigned reinterpretation is exact
  assign mag = re * re + im * im;
  assign upd = idx == 4'd0 || mag > max;
  assign nmax = upd ? mag : max;
  always_ff @(posedge clk)
    if (cap) frame <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      max <= '0;
      best <= '0;
      freq_q <= '0;
      peak_q <= '0;
    end else if (cap) begin
      state <= SCAN;
      idx <= '0;
      max <= '0;
      best <= '0;
    end else if (state == SCAN) begin
      max <= nmax;
      best <= upd ? idx : best;
      idx <= idx + 4'd1;
      if (idx == 4'd15) begin
        state <= REPORT;
        freq_q <= upd ? idx : best;
        peak_q <= nmax;
      end
    end else if (state == REPORT) begin
      state <= IDLE;
    end
  end
  assign bus.done = state == REPORT;
  assign bus.busy = state == SCAN;
  assign bus.freq = freq_q;
  assign bus.peak_mag = peak_q;
endmodule

// File: tb/tb_freq_analyzer.sv
// tb_freq_analyzer: directed and random frames checked against a cycle-level argmax model
module tb_freq_analyzer;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  freq_analyzer_if #(.DW(16)) bus();
  freq_analyzer #(.DW(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [31:0] d [16];
  assign bus.fft_d0 = d[0];   assign bus.fft_d1 = d[1];   assign bus.fft_d2 = d[2];   assign bus.fft_d3 = d[3];
  assign bus.fft_d4 = d[4];   assign bus.fft_d5 = d[5];   assign bus.fft_d6 = d[6];   assign bus.fft_d7 = d[7];
  assign bus.fft_d8 = d[8];   assign bus.fft_d9 = d[9];   assign bus.fft_d10 = d[10]; assign bus.fft_d11 = d[11];
  assign bus.fft_d12 = d[12]; assign bus.fft_d13 = d[13]; assign bus.fft_d14 = d[14]; assign bus.fft_d15 = d[15];
  int tests = 0, fails = 0;
  bit pend = 0;
  int cnt = 0;
  logic [31:0] rf, rp, hf = 0, hp = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h) t=%0t", tag, got, got, exp, exp, $time);
    end
  endtask
  function automatic logic [31:0] pack(input int re, input int im);
    logic [31:0] w;
    w = {re[15:0], im[15:0]};
    return w;
  endfunction
  task automatic ref_frame(output logic [31:0] f, output logic [31:0] p);
    longint re, im, m, bm;
    bm = -1;
    f = 0;
    for (int k = 0; k < 16; k++) begin
      re = $signed(d[k][31:16]);
      im = $signed(d[k][15:0]);
      m = re * re + im * im;
      if (m > bm) begin bm = m; f = k; end
    end
    p = bm[31:0];
  endtask
  task automatic cycle(input logic v, input logic r);
    bit acc;
    bus.fft_valid = v;
    rst = r;
    @(negedge clk);
    if (pend && cnt == 17) begin hf = rf; hp = rp; end
    check("done", bus.done, pend && cnt == 17);
    check("busy", bus.busy, pend && cnt <= 16);
    check("freq", bus.freq, hf);
    check("peak_mag", bus.peak_mag, hp);
    acc = v && (!pend || cnt == 17);
    if (r) begin
      pend = 0; hf = 0; hp = 0;
    end else begin
      if (pend) begin if (cnt == 17) pend = 0; else cnt++; end
      if (acc) begin pend = 1; cnt = 1; ref_frame(rf, rp); end
    end
    @(posedge clk);
    #1;
    bus.fft_valid = 0;
    rst = 0;
    for (int k = 0; k < 16; k++) d[k] = $urandom;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0);
  endtask
  task automatic fill(input int re, input int im);
    for (int k = 0; k < 16; k++) d[k] = pack(re, im);
  endtask
  initial begin
    bus.fft_valid = 0;
    for (int k = 0; k < 16; k++) d[k] = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_done", bus.done, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_freq", bus.freq, 0);
    check("rst_peak", bus.peak_mag, 0);
    rst = 0;
    fill(10, 10); d[5] = pack(300, -400);
    cycle(1, 0); idle(17);
    check("single_freq", bus.freq, 5);
    check("single_peak", bus.peak_mag, 250000);
    fill(0, 0); d[3] = pack(1000, 0); d[12] = pack(1000, 0);
    cycle(1, 0); idle(17);
    check("tie_freq", bus.freq, 3);
    check("tie_peak", bus.peak_mag, 1000000);
    fill(0, 0);
    cycle(1, 0); idle(17);
    check("zero_freq", bus.freq, 0);
    check("zero_peak", bus.peak_mag, 0);
    fill(1, 1); d[15] = pack(-32768, -32768); d[0] = pack(32767, 32767);
    cycle(1, 0); idle(17);
    check("ext_freq", bus.freq, 15);
    check("ext_peak", bus.peak_mag, 32'h8000_0000);
    fill(10, 10); d[2] = pack(2000, 0);
    cycle(1, 0); idle(7);
    fill(10, 10); d[9] = pack(2000, 0);
    cycle(1, 0); idle(8);
    fill(10, 10); d[9] = pack(0, -3000);
    cycle(1, 0);
    check("b2b_freq_a", bus.freq, 2);
    idle(17);
    check("b2b_freq_c", bus.freq, 9);
    check("b2b_peak_c", bus.peak_mag, 9000000);
    fill(10, 10); d[7] = pack(300, -400);
    cycle(1, 0); idle(7);
    cycle(0, 1);
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_freq", bus.freq, 0);
    idle(1);
    fill(10, 10); d[7] = pack(300, -400);
    cycle(1, 0); idle(17);
    check("after_rst_freq", bus.freq, 7);
    check("after_rst_peak", bus.peak_mag, 250000);
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < 16; k++)
        d[k] = (n % 3 == 0) ? pack($urandom_range(0, 3) * 100, 0) : $urandom;
      cycle(1, 0);
      idle($urandom_range(0, 22));
      if ($urandom_range(0, 9) == 0) cycle($urandom_range(0, 1), 1);
    end
    idle(20);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
